// File: rtl/paint_sprite_blit.sv
// Sprite ROM to frame RAM blitter with credit-limited reads and a skid FIFO.
// Build option: define PAINT_SPRITE_CLIP_EN to skip pixels outside FRAME_W x FRAME_H.
module paint_sprite_blit #(
  parameter int COOR_WIDTH        = 11,
  parameter int ROM_WIDTH         = 19,
  parameter int SPRITE_WIDTH      = 2446,
  parameter int PALETTE_WIDTH     = 2,
  parameter int ROM_LATENCY       = 1,
  parameter int TRANSPARENT_INDEX = 0,
  parameter int FRAME_W           = 800,
  parameter int FRAME_H           = 600
) (
  input  logic                     clk_33m,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [COOR_WIDTH-1:0]    sprite_x,
  input  logic [COOR_WIDTH-1:0]    sprite_y,
  input  logic [COOR_WIDTH-1:0]    frame_x,
  input  logic [COOR_WIDTH-1:0]    frame_y,
  input  logic [COOR_WIDTH-1:0]    width,
  input  logic [COOR_WIDTH-1:0]    height,
  input  logic                     flip_x,
  input  logic                     transparent_en,
  output logic                     busy,
  output logic                     done,
  output logic [ROM_WIDTH-1:0]     rom_addr,
  input  logic [PALETTE_WIDTH-1:0] rom_data,
  output logic                     write_valid,
  input  logic                     write_ready,
  output logic [COOR_WIDTH-1:0]    write_x,
  output logic [COOR_WIDTH-1:0]    write_y,
  output logic [PALETTE_WIDTH-1:0] write_palette
);

  localparam int DEPTH = ROM_LATENCY + 2;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t                  state_reg;
  logic [COOR_WIDTH-1:0]   sx_reg, sy_reg, fx_reg, fy_reg, w_reg, h_reg, x_reg, y_reg;
  logic                    flip_reg, ten_reg, busy_reg, done_reg;

  logic                    tag_valid_reg [ROM_LATENCY];
  logic [COOR_WIDTH-1:0]   tag_x_reg     [ROM_LATENCY];
  logic [COOR_WIDTH-1:0]   tag_y_reg     [ROM_LATENCY];

  logic [COOR_WIDTH-1:0]   fifo_x_reg [DEPTH];
  logic [COOR_WIDTH-1:0]   fifo_y_reg [DEPTH];
  logic [PALETTE_WIDTH-1:0] fifo_p_reg [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]        fifo_cnt_reg, inflight_reg, fifo_cnt_next, inflight_next;

  logic [COOR_WIDTH-1:0]   dest_x, dest_y;
  logic [ROM_WIDTH-1:0]    src_col, src_row, src_addr;
  logic                    clip_skip, credit_ok, issue, step, tag_out_valid, drop, push, pop;

  assign dest_x = fx_reg + x_reg;
  assign dest_y = fy_reg + y_reg;

`ifdef PAINT_SPRITE_CLIP_EN
  assign clip_skip = (({1'b0, fx_reg} + {1'b0, x_reg}) >= (COOR_WIDTH+1)'(FRAME_W)) ||
                     (({1'b0, fy_reg} + {1'b0, y_reg}) >= (COOR_WIDTH+1)'(FRAME_H));
`else
  assign clip_skip = 1'b0;
`endif

  assign credit_ok = ({1'b0, inflight_reg} + {1'b0, fifo_cnt_reg}) < (CNT_W+1)'(DEPTH);
  assign step      = (state_reg == SCAN) && (clip_skip || credit_ok);
  assign issue     = (state_reg == SCAN) && !clip_skip && credit_ok;

  // Modular arithmetic at ROM_WIDTH gives the same bits as truncating the full product.
  assign src_col  = flip_reg ? (ROM_WIDTH'(sx_reg) + ROM_WIDTH'(w_reg) - ROM_WIDTH'(x_reg) - ROM_WIDTH'(1))
                             : (ROM_WIDTH'(sx_reg) + ROM_WIDTH'(x_reg));
  assign src_row  = ROM_WIDTH'(sy_reg) + ROM_WIDTH'(y_reg);
  assign src_addr = src_col + src_row * ROM_WIDTH'(SPRITE_WIDTH);
  assign rom_addr = issue ? src_addr : '0;

  assign tag_out_valid = tag_valid_reg[ROM_LATENCY-1];
  assign drop          = ten_reg && (rom_data == PALETTE_WIDTH'(TRANSPARENT_INDEX));
  assign push          = tag_out_valid && !drop;
  assign pop           = write_valid && write_ready;
  assign fifo_cnt_next = fifo_cnt_reg + CNT_W'(push) - CNT_W'(pop);
  assign inflight_next = inflight_reg + CNT_W'(issue) - CNT_W'(tag_out_valid);

  assign write_valid   = (fifo_cnt_reg != '0);
  assign write_x       = write_valid ? fifo_x_reg[rd_ptr_reg] : '0;
  assign write_y       = write_valid ? fifo_y_reg[rd_ptr_reg] : '0;
  assign write_palette = write_valid ? fifo_p_reg[rd_ptr_reg] : '0;
  assign busy          = busy_reg;
  assign done          = done_reg;

  genvar gi;
  generate
    for (gi = 0; gi < ROM_LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_first
        always_ff @(posedge clk_33m or negedge rst_n) begin
          if (!rst_n) begin
            tag_valid_reg[gi] <= 1'b0;
            tag_x_reg[gi]     <= '0;
            tag_y_reg[gi]     <= '0;
          end else begin
            tag_valid_reg[gi] <= issue;
            tag_x_reg[gi]     <= dest_x;
            tag_y_reg[gi]     <= dest_y;
          end
        end
      end else begin : g_next
        always_ff @(posedge clk_33m or negedge rst_n) begin
          if (!rst_n) begin
            tag_valid_reg[gi] <= 1'b0;
            tag_x_reg[gi]     <= '0;
            tag_y_reg[gi]     <= '0;
          end else begin
            tag_valid_reg[gi] <= tag_valid_reg[gi-1];
            tag_x_reg[gi]     <= tag_x_reg[gi-1];
            tag_y_reg[gi]     <= tag_y_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_33m) begin
    if (push) begin
      fifo_x_reg[wr_ptr_reg] <= tag_x_reg[ROM_LATENCY-1];
      fifo_y_reg[wr_ptr_reg] <= tag_y_reg[ROM_LATENCY-1];
      fifo_p_reg[wr_ptr_reg] <= rom_data;
    end
  end

  always_ff @(posedge clk_33m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
      inflight_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_reg + PTR_W'(1);
      fifo_cnt_reg <= fifo_cnt_next;
      inflight_reg <= inflight_next;
    end
  end

  always_ff @(posedge clk_33m or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      sx_reg    <= '0;
      sy_reg    <= '0;
      fx_reg    <= '0;
      fy_reg    <= '0;
      w_reg     <= '0;
      h_reg     <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      flip_reg  <= 1'b0;
      ten_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (start) begin
            sx_reg   <= sprite_x;
            sy_reg   <= sprite_y;
            fx_reg   <= frame_x;
            fy_reg   <= frame_y;
            w_reg    <= width;
            h_reg    <= height;
            flip_reg <= flip_x;
            ten_reg  <= transparent_en;
            x_reg    <= '0;
            y_reg    <= '0;
            busy_reg <= 1'b1;
            // An empty blit crosses the already-empty DRAIN so done lands at T+2.
            state_reg <= ((width == '0) || (height == '0)) ? DRAIN : SCAN;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        SCAN: begin
          if (step) begin
            if (x_reg == w_reg - COOR_WIDTH'(1)) begin
              x_reg <= '0;
              if (y_reg == h_reg - COOR_WIDTH'(1)) state_reg <= DRAIN;
              else y_reg <= y_reg + COOR_WIDTH'(1);
            end else begin
              x_reg <= x_reg + COOR_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          // Look one cycle ahead so done follows the last accepted write directly.
          if ((inflight_next == '0) && (fifo_cnt_next == '0)) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_paint_sprite_blit.sv
// Directed bench for paint_sprite_blit: one latency-1 and one latency-3 instance.
module tb_paint_sprite_blit;

  logic clk_33m = 1'b0;
  always #15 clk_33m = ~clk_33m;

  logic        rst_n;
  logic [10:0] sprite_x, sprite_y, frame_x, frame_y, width, height;
  logic        flip_x, transparent_en;
  logic        start1, start3, ready1, ready3;
  logic        busy1, done1, wv1, busy3, done3, wv3;
  logic [18:0] addr1, addr3;
  logic [1:0]  rd1, rd3, wp1, wp3, p3a, p3b;
  logic [10:0] wx1, wy1, wx3, wy3;

  paint_sprite_blit #(.ROM_LATENCY(1)) dut1 (
    .clk_33m(clk_33m), .rst_n(rst_n), .start(start1),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .frame_x(frame_x), .frame_y(frame_y),
    .width(width), .height(height), .flip_x(flip_x), .transparent_en(transparent_en),
    .busy(busy1), .done(done1), .rom_addr(addr1), .rom_data(rd1),
    .write_valid(wv1), .write_ready(ready1), .write_x(wx1), .write_y(wy1), .write_palette(wp1));

  paint_sprite_blit #(.ROM_LATENCY(3)) dut3 (
    .clk_33m(clk_33m), .rst_n(rst_n), .start(start3),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .frame_x(frame_x), .frame_y(frame_y),
    .width(width), .height(height), .flip_x(flip_x), .transparent_en(transparent_en),
    .busy(busy3), .done(done3), .rom_addr(addr3), .rom_data(rd3),
    .write_valid(wv3), .write_ready(ready3), .write_x(wx3), .write_y(wy3), .write_palette(wp3));

  // Sprite ROM contents: value = (addr + 3) mod 4, so address 12241 holds 0.
  function automatic logic [1:0] rom_val(input logic [18:0] a);
    return a[1:0] + 2'd3;
  endfunction

  always @(posedge clk_33m) begin
    rd1 <= rom_val(addr1);
    p3a <= rom_val(addr3);
    p3b <= p3a;
    rd3 <= p3b;
  end

  bit          sel;
  logic        o_busy, o_done, o_valid;
  logic [18:0] o_addr;
  logic [10:0] o_x, o_y;
  logic [1:0]  o_pal;
  assign o_busy  = sel ? busy3 : busy1;
  assign o_done  = sel ? done3 : done1;
  assign o_valid = sel ? wv3 : wv1;
  assign o_addr  = sel ? addr3 : addr1;
  assign o_x     = sel ? wx3 : wx1;
  assign o_y     = sel ? wy3 : wy1;
  assign o_pal   = sel ? wp3 : wp1;

  int n_assert = 0;
  int n_fail   = 0;
  logic [10:0] cx[$], cy[$];
  logic [1:0]  cp[$];
  int          cyc[$];
  int          ex[$], ey[$], ep[$];
  int          done_cyc, done_cnt, issue_early;
  bit          any_valid, any_busy;
  logic        busy_k1;
  logic [18:0] addr_k1;
  bit [3:0]    pat = 4'b1001;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic launch(input bit s, input int sx, input int sy, input int fx, input int fy,
                        input int w, input int h, input bit fl, input bit te);
    sprite_x = 11'(sx); sprite_y = 11'(sy); frame_x = 11'(fx); frame_y = 11'(fy);
    width = 11'(w); height = 11'(h); flip_x = fl; transparent_en = te;
    if (s) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk_33m); #1;
    start1 = 1'b0; start3 = 1'b0;
  endtask

  // mode 0: ready always 1; mode 1: repeating 1001 pattern; mode 2: ready 0 until cycle 15.
  task automatic capture(input bit s, input int mode, input int ncyc);
    bit rdy;
    bit prev_stall = 1'b0;
    logic [23:0] prev_out = '0;
    sel = s;
    cx.delete(); cy.delete(); cp.delete(); cyc.delete();
    done_cyc = -1; done_cnt = 0; issue_early = 0; any_valid = 0; any_busy = 0;
    for (int k = 1; k <= ncyc; k++) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[k % 4] : (k >= 15);
      if (s) ready3 = rdy; else ready1 = rdy;
      @(negedge clk_33m);
      if (k == 1) begin busy_k1 = o_busy; addr_k1 = o_addr; end
      if (o_addr != '0 && k < 15) issue_early++;
      if (prev_stall) check("hold while stalled", {o_valid, o_x, o_y, o_pal}, {1'b1, prev_out});
      if (o_valid) any_valid = 1;
      if (o_busy) any_busy = 1;
      if (o_valid && rdy) begin cx.push_back(o_x); cy.push_back(o_y); cp.push_back(o_pal); cyc.push_back(k); end
      prev_stall = o_valid && !rdy;
      prev_out   = {o_x, o_y, o_pal};
      if (o_done) begin done_cnt++; if (done_cyc < 0) done_cyc = k; end
      $display("cycle %0d sel=%0d busy=%0d addr=%0d valid=%0d ready=%0d x=%0d y=%0d pal=%0d done=%0d",
               k, s, o_busy, o_addr, o_valid, rdy, o_x, o_y, o_pal, o_done);
      @(posedge clk_33m); #1;
    end
    ready1 = 1'b1; ready3 = 1'b1;
  endtask

  task automatic compare_writes(input string tag);
    check({tag, " write count"}, cx.size(), ex.size());
    for (int i = 0; i < ex.size(); i++)
      if (i < cx.size())
        check({tag, " write"}, {cx[i], cy[i], cp[i]}, {11'(ex[i]), 11'(ey[i]), 2'(ep[i])});
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; ready1 = 1'b1; ready3 = 1'b1;
    sprite_x = '0; sprite_y = '0; frame_x = '0; frame_y = '0; width = '0; height = '0;
    flip_x = 1'b0; transparent_en = 1'b0;
    repeat (3) @(posedge clk_33m); #1;
    check("reset lat1", {busy1, done1, wv1, addr1, wx1, wy1, wp1}, '0);
    check("reset lat3", {busy3, done3, wv3, addr3, wx3, wy3, wp3}, '0);
    @(negedge clk_33m); rst_n = 1'b1;
    @(posedge clk_33m); #1;

    // Plain 3x2 blit, latency 1.
    ex = '{100, 101, 102, 100, 101, 102}; ey = '{50, 50, 50, 51, 51, 51}; ep = '{3, 0, 1, 1, 2, 3};
    launch(0, 10, 5, 100, 50, 3, 2, 0, 0);
    capture(0, 0, 20);
    check("t1 busy at T+1", busy_k1, 1);
    check("t1 first rom_addr", addr_k1, 12240);
    compare_writes("t1");
    check("t1 first write cycle", (cyc.size() > 0) ? cyc[0] : -1, 3);
    check("t1 last write cycle", (cyc.size() > 0) ? cyc[cyc.size()-1] : -1, 8);
    check("t1 done cycle", done_cyc, 9);
    check("t1 done count", done_cnt, 1);

    // Mirrored.
    ep = '{1, 0, 3, 3, 2, 1};
    launch(0, 10, 5, 100, 50, 3, 2, 1, 0);
    capture(0, 0, 20);
    check("t2 first rom_addr", addr_k1, 12242);
    compare_writes("t2");
    check("t2 done cycle", done_cyc, 9);

    // Transparent pixel at (1,0) dropped.
    ex = '{100, 102, 100, 101, 102}; ey = '{50, 50, 51, 51, 51}; ep = '{3, 1, 1, 2, 3};
    launch(0, 10, 5, 100, 50, 3, 2, 0, 1);
    capture(0, 0, 20);
    compare_writes("t3");
    check("t3 done count", done_cnt, 1);

    // Latency 3 with toggling backpressure.
    ex = '{100, 101, 102, 100, 101, 102}; ey = '{50, 50, 50, 51, 51, 51}; ep = '{3, 0, 1, 1, 2, 3};
    launch(1, 10, 5, 100, 50, 3, 2, 0, 0);
    capture(1, 1, 40);
    compare_writes("t4");
    check("t4 done count", done_cnt, 1);

    // Latency 3, writer stalled: reads must stop after five credits.
    launch(1, 10, 5, 100, 50, 3, 2, 0, 0);
    capture(1, 2, 30);
    check("t5 reads while stalled", issue_early, 5);
    compare_writes("t5");
    check("t5 first write cycle", (cyc.size() > 0) ? cyc[0] : -1, 15);
    check("t5 done cycle", done_cyc, 21);

    // Zero-width blit.
    launch(0, 10, 5, 100, 50, 0, 2, 0, 0);
    capture(0, 0, 8);
    check("t6 busy at T+1", busy_k1, 1);
    check("t6 no write_valid", any_valid, 0);
    check("t6 done cycle", done_cyc, 2);
    check("t6 done count", done_cnt, 1);

    // Right frame edge.
`ifdef PAINT_SPRITE_CLIP_EN
    ex = '{798, 799}; ey = '{10, 10}; ep = '{3, 0};
`else
    ex = '{798, 799, 800, 801}; ey = '{10, 10, 10, 10}; ep = '{3, 0, 1, 2};
`endif
    launch(0, 0, 0, 798, 10, 4, 1, 0, 0);
    capture(0, 0, 14);
    compare_writes("t7");
    check("t7 done count", done_cnt, 1);

    // Reset in the middle of a blit.
    launch(0, 10, 5, 100, 50, 3, 2, 0, 0);
    @(posedge clk_33m); #1;
    @(posedge clk_33m); #1;
    check("t8 valid before reset", wv1, 1);
    rst_n = 1'b0;
    #1;
    check("t8 outputs in reset", {busy1, done1, wv1, addr1, wx1, wy1, wp1}, '0);
    @(negedge clk_33m); rst_n = 1'b1;
    @(posedge clk_33m); #1;
    capture(0, 0, 15);
    check("t8 no writes after reset", any_valid, 0);
    check("t8 no busy after reset", any_busy, 0);
    check("t8 no done after reset", done_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
